// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// arm_pkg : ID/EX bundle layout (LSB-first offsets) and pipeline-register state.
// Revision: 1.0
// ============================================================================
package arm_pkg;

   localparam int ID_EX_W = 146;

   localparam int DEST_W        = 4;
   localparam int SIMM24_W      = 24;
   localparam int SHIFT_OP_W    = 12;
   localparam int VAL_W         = 32;
   localparam int PC_W          = 32;
   localparam int EXE_CMD_W     = 4;

   localparam int DEST_LSB      = 0;
   localparam int SIMM24_LSB    = 4;
   localparam int SHIFT_OP_LSB  = 28;
   localparam int IMM_BIT       = 40;
   localparam int VAL_RM_LSB    = 41;
   localparam int VAL_RN_LSB    = 73;
   localparam int PC_LSB        = 105;
   localparam int EXE_CMD_LSB   = 137;
   localparam int S_BIT         = 141;
   localparam int B_BIT         = 142;
   localparam int MEM_W_EN_BIT  = 143;
   localparam int MEM_R_EN_BIT  = 144;
   localparam int WB_EN_BIT     = 145;

   // Encoding equals the number of held entries, so occupancy is a plain cast.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_e;

   function automatic logic [1:0] state_occ(input pipe_state_e s);
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : saturating up-counter with synchronous clear (clear wins).
// Revision: 1.0
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// id_ex_pipe_reg : valid/ready ID->EXE register with flush and stall counter.
// Define PIPE_REG_SKID_EN for the 2-entry skid build with registered in_ready.
// Revision: 1.0
// ============================================================================
module id_ex_pipe_reg
   import arm_pkg::*;
#(
   parameter int WIDTH = ID_EX_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occ,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   pipe_state_e      state_q;
   pipe_state_e      state_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_d;
   logic             in_fire;
   logic             out_fire;

   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign occ       = state_occ(state_q);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

`ifdef PIPE_REG_SKID_EN
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_d;
   logic             in_ready_q;

   assign in_ready = in_ready_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Zeroed bundle keeps WB_EN/MEM_W_EN/B/S low downstream.
         state_d = ST_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_ONE;
                  main_d  = in_data;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = ST_TWO;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != ST_TWO);
      end
   end
`else
   // Single entry: a new bundle may enter only when the held one leaves this cycle.
   assign in_ready = ~out_valid | out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_ONE;
                  main_d  = in_data;
               end
            end
            ST_ONE: begin
               if (in_fire) begin
                  main_d = in_data;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end
`endif

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (out_valid & ~out_ready),
      .clr_i (clr_cnt),
      .cnt_o (stall_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// tb_id_ex_pipe_reg : scoreboard bench for id_ex_pipe_reg (either build).
// Revision: 1.0
// ============================================================================
module tb_id_ex_pipe_reg;

   localparam int W  = 146;
   localparam int CW = 4;
`ifdef PIPE_REG_SKID_EN
   localparam int MAXOCC = 2;
`else
   localparam int MAXOCC = 1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [1:0]    occ;
   logic          clr_cnt;
   logic [CW-1:0] stall_cnt;

   int            checks    = 0;
   int            failures  = 0;
   int            delivered = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  mon_exp;

   always #5 clk = ~clk;

   id_ex_pipe_reg #(
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occ       (occ),
      .clr_cnt   (clr_cnt),
      .stall_cnt (stall_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero_data(input string name);
      checks++;
      if (out_data !== '0) begin
         failures++;
         $display("FAIL %s: got %h expected 0", name, out_data);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Input side of the scoreboard: every accepted bundle is expected downstream.
   always @(negedge clk) begin
      if (rst || flush) begin
         exp_q.delete();
      end else if (in_valid && in_ready) begin
         exp_q.push_back(in_data);
      end
   end

   // Output side: each transfer to EXE must match the oldest accepted bundle.
   always @(negedge clk) begin
      if (!rst && !flush && out_valid && out_ready) begin
         checks++;
         delivered++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_data: got unexpected bundle %h expected none", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) begin
               failures++;
               $display("FAIL out_data: got %h expected %h", out_data, mon_exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clr_cnt   = 1'b0;

      // Reset state
      tick();
      tick();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk_zero_data("rst_out_data");
      chk("rst_occ", occ, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_in_ready", in_ready, 1);

      // Stream 1..8 at full rate
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         in_valid = 1'b1;
         in_data  = W'(i);
         @(negedge clk);
         if (i > 1) chk("stream_out_valid", out_valid, 1);
      end
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("stream_drained", out_valid, 0);
      chk("stream_stall_cnt", stall_cnt, 0);
      chk("stream_delivered", delivered, 8);

      // Back-pressure with A=0x11, B=0x22
`ifdef PIPE_REG_SKID_EN
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(32'h11);
      tick();
      in_data   = W'(32'h22);
      @(negedge clk);
      chk("bp_in_ready_one", in_ready, 1);
      chk("bp_occ_one", occ, 1);
      tick();
      in_valid  = 1'b0;
      @(negedge clk);
      chk("bp_occ_two", occ, 2);
      chk("bp_in_ready_two", in_ready, 0);
      tick();
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_stall_cnt", stall_cnt, 3);
      chk("bp_occ_held", occ, 2);
      chk("bp_in_ready_reg", in_ready, 0);
      tick();
      tick();
`else
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(32'h11);
      @(negedge clk);
      chk("bp_in_ready_empty", in_ready, 1);
      tick();
      in_data   = W'(32'h22);
      @(negedge clk);
      chk("bp_in_ready_comb_low", in_ready, 0);
      chk("bp_occ_one", occ, 1);
      tick();
      tick();
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_stall_cnt", stall_cnt, 3);
      chk("bp_in_ready_comb_high", in_ready, 1);
      tick();
      in_valid  = 1'b0;
      tick();
`endif
      @(negedge clk);
      chk("bp_drained", out_valid, 0);
      chk("bp_delivered", delivered, 10);

      // Flush with the register full and a bundle offered
      tick();
      clr_cnt   = 1'b1;
      out_ready = 1'b0;
      tick();
      clr_cnt   = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(32'h33);
`ifdef PIPE_REG_SKID_EN
      tick();
      in_data   = W'(32'h44);
`endif
      tick();
      in_valid  = 1'b0;
      @(negedge clk);
      chk("flush_pre_occ", occ, MAXOCC);
      chk("flush_pre_in_ready", in_ready, 0);
      tick();
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = W'(32'h99);
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
      chk_zero_data("flush_out_data");
      chk("flush_occ", occ, 0);
      chk("flush_in_ready", in_ready, 1);
      chk("flush_keeps_stall_cnt", stall_cnt, MAXOCC + 1);

      // Flush drops a bundle that fires into an empty register
      tick();
      out_ready = 1'b1;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = W'(32'h77);
      @(negedge clk);
      chk("flush_empty_in_ready", in_ready, 1);
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      chk("flush_drop_incoming", out_valid, 0);
      chk("flush_drop_occ", occ, 0);

      // Stall counter saturation and clear-over-increment
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(32'h55);
      tick();
      in_valid  = 1'b0;
      repeat (20) tick();
      @(negedge clk);
      chk("sat_stall_cnt", stall_cnt, 15);
      tick();
      clr_cnt   = 1'b1;
      tick();
      clr_cnt   = 1'b0;
      @(negedge clk);
      chk("clr_wins", stall_cnt, 0);
      tick();
      @(negedge clk);
      chk("clr_then_count", stall_cnt, 1);
      tick();
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("sat_drained", out_valid, 0);

      // Reset while holding a stalled bundle
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(32'h66);
      tick();
      in_valid  = 1'b0;
      @(negedge clk);
      chk("rst_mid_occ_pre", occ, 1);
      tick();
      rst       = 1'b1;
      tick();
      rst       = 1'b0;
      @(negedge clk);
      chk("rst_mid_out_valid", out_valid, 0);
      chk_zero_data("rst_mid_out_data");
      chk("rst_mid_occ", occ, 0);
      chk("rst_mid_stall_cnt", stall_cnt, 0);
      chk("rst_mid_in_ready", in_ready, 1);
      tick();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = W'(32'h5A);
      tick();
      in_valid  = 1'b0;
      tick();
      @(negedge clk);
      chk("post_rst_drained", out_valid, 0);
      chk("total_delivered", delivered, 12);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID→EXE pipeline register: the next generation of the fixed-field ID stage register. Carries an opaque WIDTH-bit decoded-instruction bundle (default: the full ID/EX control-plus-operand bundle) with a valid/ready handshake, so EXE-side back-pressure and hazard stalls are expressed by handshake rather than a global freeze. Supports synchronous flush for taken branches, an optional 2-entry skid buffer for a registered `in_ready`, and a saturating stall-cycle counter for performance analysis. Sits between ID_Stage and the EXE stage.

## Interface
Parameters:
- WIDTH, 146, bundle width (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD[4], PC[32], Val_Rn[32], Val_Rm[32], imm, Shift_operand[12], Signed_imm_24[24], Dest[4])
- CNT_W, 16, stall counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  kill all held and incoming entries this cycle
- in_valid  in  1  ID presents a bundle
- in_ready  out  1  register accepts a bundle
- in_data  in  WIDTH  bundle from ID
- out_valid  out  1  bundle presented to EXE
- out_ready  in  1  EXE accepts bundle
- out_data  out  WIDTH  bundle to EXE
- occ  out  2  entries held (0..2)
- clr_cnt  in  1  clear stall counter
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (main valid), TWO (main + skid valid; skid build only).
- EMPTY: in_fire → ONE, main←in_data.
- ONE: in_fire & out_fire → ONE, main←in_data; in_fire & !out_ready → TWO, skid←in_data; !in_fire & out_fire → EMPTY.
- TWO: out_fire → ONE, main←skid; else hold. in_valid ignored (in_ready=0).
- out_valid = (state != EMPTY); out_data = main.
- Flush (priority over everything except rst): next state EMPTY, main and skid ← 0, incoming bundle dropped even if in_fire. Zeroed bundle guarantees WB_EN/MEM_W_EN/B/S = 0 downstream.
- Held bundle is stable while out_valid & !out_ready (no overwrite, no drop).
- stall_cnt: +1 each cycle out_valid & !out_ready, saturates at 2^CNT_W−1; clr_cnt zeroes it (clr_cnt wins over increment same cycle); not affected by flush.

## Timing
- Reset: state EMPTY, out_valid 0, out_data 0, occ 0, stall_cnt 0, in_ready 1.
- Latency: 1 cycle in_fire → out_valid.
- Throughput: 1 bundle/cycle while out_ready=1.
- Skid build: in_ready is a register output = (next state != TWO); no combinational path out_ready → in_ready.
- Flush asserted cycle N: cycle N+1 out_valid 0, occ 0, in_ready 1.
- rst mid-transfer: contents discarded, identical to power-on reset.

## Configuration
- PIPE_REG_SKID_EN defined: 2-entry skid buffer as above, registered in_ready, occ up to 2.
- Undefined: single entry, no TWO state, in_ready = !out_valid | out_ready (combinational), occ ∈ {0,1}; all other behaviour (flush, counter, reset) identical.

## Structure
- Shared package `arm_pkg`: ID/EX bundle field widths and bit offsets, ID_EX_W = 146 constant, state enum {EMPTY, ONE, TWO}.
- One sub-module: `sat_counter` (CNT_W, inc, clr, saturation) for stall_cnt.
- Bundle packing/unpacking stays in the ID module wrapper, not here.

## Test plan
- Stream: out_ready=1, in_data=1..8 on 8 consecutive cycles → out_data 1..8 one cycle later, out_valid continuous, stall_cnt 0.
- Back-pressure (skid build): send A=0x11, B=0x22, drop out_ready 3 cycles → occ 2, in_ready 0, stall_cnt 3; release → A then B delivered, none lost or duplicated.
- Flush with in_fire and occ 2 → next cycle out_valid 0, out_data 0, occ 0, in_ready 1; flushed and incoming bundles never appear.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles → stall_cnt 15; clr_cnt with stall active → 0 next cycle.
- rst asserted while occ 1 and out_ready=0 → all outputs reset values next cycle; subsequent bundle 0x5A delivered normally.
- Build without PIPE_REG_SKID_EN: out_ready low with occ 1 → in_ready 0 same cycle; out_ready high → in_ready 1 same cycle, simultaneous in/out fire sustains throughput.
